// File: rtl/array_mult_pkg.sv
// Shared definitions for the pipelined array multiplier.
//   calc_lat  : pipeline depth, ceil(width / rows)
//   PW_MULT   : product width factor (product is PW_MULT * WIDTH bits)
//   stage_t   : payload carried by every pipeline register, sized for the
//               widest legal operand; narrower builds leave upper bits zero.
package array_mult_pkg;

    localparam int PW_MULT   = 2;
    localparam int MAX_WIDTH = 16;

    typedef struct packed {
        logic                            valid;
        logic [PW_MULT*MAX_WIDTH-1:0]    sum;
        logic [MAX_WIDTH-1:0]            a;
        logic [MAX_WIDTH-1:0]            b_rem;
        logic                            sgn;
    } stage_t;

    function automatic int calc_lat(input int width, input int rows);
        return (width + rows - 1) / rows;
    endfunction

endpackage

// File: rtl/array_mult_stage.sv
// One pipeline stage of the array multiplier: adds ROW_CNT partial-product
// rows starting at absolute row ROW_LO, then registers the result.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   adv        : shift enable; low holds the register
//   d_in       : payload from the previous stage (or the input operands)
//   q          : registered payload for the next stage
// Optional macro ARRAY_MULT_SIGNED_EN: when defined, payloads flagged sgn are
// treated as two's complement (sign-extended rows, top row subtracted).
module array_mult_stage
    import array_mult_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int ROW_LO  = 0,
    parameter int ROW_CNT = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   adv,
    input  stage_t d_in,
    output stage_t q
);

    localparam int PW = PW_MULT * WIDTH;

    stage_t        q_reg;
    stage_t        q_next;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] row;
    logic [PW-1:0] acc;
    logic          unused_sum;

    // Only the low PW bits of the running sum are meaningful at this width.
    assign unused_sum = ^d_in.sum;

    always_comb begin
        a_ext = {{(PW-WIDTH){1'b0}}, d_in.a[WIDTH-1:0]};
`ifdef ARRAY_MULT_SIGNED_EN
        if (d_in.sgn) begin
            a_ext = {{(PW-WIDTH){d_in.a[WIDTH-1]}}, d_in.a[WIDTH-1:0]};
        end
`endif
        acc = d_in.sum[PW-1:0];
        row = '0;
        // b_rem has already been shifted by earlier stages, so the local row
        // index j selects bit j while the weight uses the absolute row index.
        for (int j = 0; j < ROW_CNT; j++) begin
            row = d_in.b_rem[j] ? (a_ext << (ROW_LO + j)) : '0;
`ifdef ARRAY_MULT_SIGNED_EN
            // The sign bit of B carries negative weight in two's complement.
            if (d_in.sgn && (ROW_LO + j == WIDTH - 1)) begin
                acc = acc - row;
            end else begin
                acc = acc + row;
            end
`else
            acc = acc + row;
`endif
        end

        q_next              = '0;
        q_next.valid        = d_in.valid;
        q_next.sum[PW-1:0]  = acc;
        q_next.a            = d_in.a;
        q_next.b_rem        = d_in.b_rem >> ROW_CNT;
        q_next.sgn          = d_in.sgn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (adv) begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/array_mult_pipe.sv
// Pipelined unsigned array multiplier, P = A x B, one product per cycle.
// ROWS_PER_STAGE partial-product rows are reduced per register stage; the
// pipe is LAT = ceil(WIDTH/ROWS_PER_STAGE) stages deep and stalls as a whole.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   ena                  : global enable, low freezes all state
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b                 : WIDTH-bit operands
//   sgn                  : two's complement select (ARRAY_MULT_SIGNED_EN only)
//   out_valid / out_ready: product handshake
//   p                    : 2*WIDTH-bit product
//   busy                 : any stage holds a valid product
// Optional macro ARRAY_MULT_SIGNED_EN adds the sgn port and signed support.
module array_mult_pipe
    import array_mult_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int ROWS_PER_STAGE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
`ifdef ARRAY_MULT_SIGNED_EN
    input  logic                   sgn,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     p,
    output logic                   busy
);

    localparam int LAT = calc_lat(WIDTH, ROWS_PER_STAGE);
    localparam int PW  = PW_MULT * WIDTH;

    stage_t           stage_in;
    stage_t           stage_q [LAT];
    logic [LAT-1:0]   valid_vec;
    logic             advance;
    logic             unused_tail;

    // All stages move together; no bubble squeezing, so an empty output
    // register is enough to let the whole pipe shift.
    assign advance  = ena && (!out_valid || out_ready);
    assign in_ready = advance;

    always_comb begin
        stage_in                  = '0;
        stage_in.valid            = in_valid;
        stage_in.a[WIDTH-1:0]     = a;
        stage_in.b_rem[WIDTH-1:0] = b;
`ifdef ARRAY_MULT_SIGNED_EN
        stage_in.sgn              = sgn;
`endif
    end

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            localparam int ROW_LO  = gi * ROWS_PER_STAGE;
            // The last stage absorbs whatever rows remain.
            localparam int ROW_CNT = (gi == LAT - 1) ? (WIDTH - ROW_LO) : ROWS_PER_STAGE;

            if (gi == 0) begin : g_first
                array_mult_stage #(
                    .WIDTH   (WIDTH),
                    .ROW_LO  (ROW_LO),
                    .ROW_CNT (ROW_CNT)
                ) u_stage (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .adv   (advance),
                    .d_in  (stage_in),
                    .q     (stage_q[gi])
                );
            end else begin : g_rest
                array_mult_stage #(
                    .WIDTH   (WIDTH),
                    .ROW_LO  (ROW_LO),
                    .ROW_CNT (ROW_CNT)
                ) u_stage (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .adv   (advance),
                    .d_in  (stage_q[gi-1]),
                    .q     (stage_q[gi])
                );
            end

            assign valid_vec[gi] = stage_q[gi].valid;
        end
    endgenerate

    assign out_valid = stage_q[LAT-1].valid;
    assign p         = stage_q[LAT-1].sum[PW-1:0];
    assign busy      = |valid_vec;

    // Operand copies and spare sum bits are not needed past the last stage.
    assign unused_tail = ^{stage_q[LAT-1].sum, stage_q[LAT-1].a,
                           stage_q[LAT-1].b_rem, stage_q[LAT-1].sgn};

endmodule

// File: tb/tb_array_mult_pipe.sv
module tb_array_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;

    // WIDTH=4, ROWS_PER_STAGE=1 instance
    logic        in_valid, in_ready, out_valid, out_ready, busy, sgn;
    logic [3:0]  a, b;
    logic [7:0]  p;

    // WIDTH=7, ROWS_PER_STAGE=3 instance
    logic        in_valid7, in_ready7, out_valid7, out_ready7, busy7;
    logic [6:0]  a7, b7;
    logic [13:0] p7;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int first_ret, last_ret, n_ret, c0, first7;
    logic [7:0]  hp;
    logic        hv, hb;
    logic [7:0]  sb  [$];
    logic [13:0] sb7 [$];

    always #5 clk = ~clk;

    array_mult_pipe #(.WIDTH(4), .ROWS_PER_STAGE(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef ARRAY_MULT_SIGNED_EN
        .sgn       (sgn),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    array_mult_pipe #(.WIDTH(7), .ROWS_PER_STAGE(3)) u_dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid7),
        .in_ready  (in_ready7),
        .a         (a7),
        .b         (b7),
`ifdef ARRAY_MULT_SIGNED_EN
        .sgn       (1'b0),
`endif
        .out_valid (out_valid7),
        .out_ready (out_ready7),
        .p         (p7),
        .busy      (busy7)
    );

    function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y, input logic s);
        logic signed [7:0] sx, sy, sp;
        if (s) begin
            sx = 8'($signed(x));
            sy = 8'($signed(y));
            sp = sx * sy;
            return sp;
        end
        return {4'b0, x} * {4'b0, y};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the 4-bit instance: sample handshakes before the
    // edge, score any retiring product, record any accepted operands.
    task automatic tick();
        logic       xfer, ret;
        logic [7:0] e;
        #1;
        xfer = in_valid && in_ready;
        ret  = out_valid && out_ready && ena;
        if (ret) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("product", 32'(p), 32'(e));
                $display("cycle %0d: out p=0x%02h expected=0x%02h", cyc, p, e);
            end
            if (first_ret < 0) first_ret = cyc;
            last_ret = cyc;
            n_ret++;
        end
        if (xfer) sb.push_back(model(a, b, sgn));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 40 && sb.size() > 0; k++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic reset_counters();
        first_ret = -1;
        last_ret  = -1;
        n_ret     = 0;
        c0        = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sgn = 1'b0;
        in_valid7 = 1'b0; out_ready7 = 1'b1; a7 = '0; b7 = '0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_p",         32'(p),         32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; ena = 1'b1; out_ready = 1'b1;

        // Single transfer: 15 x 15, latency 4, busy for cycles 1..4.
        reset_counters();
        a = 4'd15; b = 4'd15; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("t1_busy",      32'(busy),      32'(k <= 4));
            check("t1_out_valid", 32'(out_valid), 32'(k == 4));
            if (k == 4) check("t1_p", 32'(p), 32'hE1);
            tick();
        end
        check("t1_latency", 32'(first_ret - c0), 32'd4);

        // Back-to-back stream of 16 operand pairs.
        reset_counters();
        for (int i = 0; i < 16; i++) begin
            a = 4'(i); b = 4'(15 - i); in_valid = 1'b1;
            tick();
        end
        drain();
        check("t2_count", 32'(n_ret), 32'd16);
        check("t2_first", 32'(first_ret - c0), 32'd4);
        check("t2_span",  32'(last_ret - first_ret), 32'd15);

        // Backpressure for 5 cycles with a full pipe.
        reset_counters();
        for (int i = 0; i < 6; i++) begin
            a = 4'(i + 1); b = 4'(i + 3); in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b0; a = 4'd9; b = 4'd9;
        #1;
        hp = p;
        for (int k = 0; k < 5; k++) begin
            check("t3_in_ready",  32'(in_ready),  32'd0);
            check("t3_out_valid", 32'(out_valid), 32'd1);
            check("t3_p_stable",  32'(p),         32'(hp));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 4'(12 - i); b = 4'(i + 10); in_valid = 1'b1;
            tick();
        end
        drain();
        check("t3_count", 32'(n_ret), 32'd10);

        // ena low for 3 cycles mid-stream.
        reset_counters();
        for (int i = 0; i < 5; i++) begin
            a = 4'(i + 2); b = 4'(13 - i); in_valid = 1'b1;
            tick();
        end
        ena = 1'b0; a = 4'd15; b = 4'd1;
        #1;
        hp = p; hv = out_valid; hb = busy;
        for (int k = 0; k < 3; k++) begin
            check("t4_in_ready",  32'(in_ready),  32'd0);
            check("t4_out_valid", 32'(out_valid), 32'(hv));
            check("t4_p_hold",    32'(p),         32'(hp));
            check("t4_busy_hold", 32'(busy),      32'(hb));
            tick();
        end
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 4'(i + 7); b = 4'(i + 4); in_valid = 1'b1;
            tick();
        end
        drain();
        check("t4_count",     32'(n_ret), 32'd8);
        check("t4_last_time", 32'(last_ret - c0), 32'd14);

        // Reset with three products in flight.
        reset_counters();
        a = 4'd5;  b = 4'd6;  in_valid = 1'b1; tick();
        a = 4'd7;  b = 4'd3;  tick();
        a = 4'd11; b = 4'd13; tick();
        in_valid = 1'b0; tick();
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_p",         32'(p),         32'd0);
        check("t5_rst_busy",      32'(busy),      32'd0);
        sb.delete();
        @(posedge clk); #1; @(posedge clk); #1;
        cyc += 2;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t5_no_stale", 32'(out_valid), 32'd0);
            tick();
        end

        // WIDTH=7, ROWS_PER_STAGE=3: remainder stage, LAT=3.
        first7 = -1;
        in_valid7 = 1'b1; a7 = 7'd127; b7 = 7'd127;
        #1;
        check("t6_in_ready7", 32'(in_ready7), 32'd1);
        sb7.push_back(14'd16129);
        @(posedge clk); #1;
        a7 = 7'd93; b7 = 7'd45;
        sb7.push_back(14'd4185);
        @(posedge clk); #1;
        in_valid7 = 1'b0;
        for (int k = 2; k < 12 && sb7.size() > 0; k++) begin
            if (out_valid7) begin
                if (first7 < 0) first7 = k;
                $display("w7 cycle %0d: out p7=%0d expected=%0d", k, p7, sb7[0]);
                check("t6_p7", 32'(p7), 32'(sb7.pop_front()));
            end
            @(posedge clk); #1;
        end
        check("t6_drain",   32'(sb7.size()), 32'd0);
        check("t6_latency", 32'(first7),     32'd3);

`ifdef ARRAY_MULT_SIGNED_EN
        // Signed and mixed-mode operands in flight together.
        reset_counters();
        sgn = 1'b1; a = 4'h8; b = 4'h8; in_valid = 1'b1; tick();
        sgn = 1'b1; a = 4'h8; b = 4'h7; tick();
        sgn = 1'b0; a = 4'h8; b = 4'h7; tick();
        sgn = 1'b1; a = 4'hD; b = 4'h5; tick();
        sgn = 1'b0;
        drain();
        check("t7_count", 32'(n_ret), 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/array_mult_pipe.md
Name: array_mult_pipe

Overview:
Parametrised, pipelined successor to the 4x4 combinational array multiplier.
- Computes P = A x B for WIDTH-bit operands; ROWS_PER_STAGE partial-product rows are reduced per register stage.
- Valid/ready handshake on both sides, whole-pipe stall on backpressure, throughput one product per cycle.
- Sits between the tile's input pins/registers and the output pins, in the same top-level wrapper slot as the current multiplier.

Parameters:
- WIDTH, 4, operand width of A and B; product is 2*WIDTH bits; legal 2..16.
- ROWS_PER_STAGE, 1, partial-product rows added per pipeline stage; legal 1..WIDTH.
- LAT (localparam), ceil(WIDTH/ROWS_PER_STAGE), pipeline depth in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- in_valid  in  1  operands presented.
- in_ready  out  1  pipe accepts operands this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- p  out  2*WIDTH  product.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (async assert, sync deassert by the wrapper): all stage valid bits 0, all data registers 0, so out_valid=0, p=0, busy=0. in_ready may be high in the first cycle after reset if ena=1.
- advance = ena && (!out_valid || out_ready). All stages shift together when advance=1, else all hold. No bubble squeezing.
- in_ready = advance, combinational; in_valid is not used to form it. Transfer occurs when in_valid && in_ready.
- Each stage register holds: valid bit, 2*WIDTH-bit partial sum, A, the not-yet-consumed bits of B.
- Stage k adds rows k*ROWS_PER_STAGE .. min((k+1)*ROWS_PER_STAGE, WIDTH)-1. Each row is (A AND b[i]) << i, zero-extended to 2*WIDTH. The last stage takes the remainder rows when WIDTH is not a multiple of ROWS_PER_STAGE.
- Latency: a product accepted in cycle N appears with out_valid=1 in cycle N+LAT, provided no stall occurs.
- Arithmetic: unsigned, exact. No overflow is possible in 2*WIDTH bits (max (2^W-1)^2).
- Output stall: out_valid && !out_ready holds p and out_valid stable. Upstream stages hold as well; in_ready=0.
- ena=0: everything holds, in_ready=0, and outputs are held (not cleared). This takes priority over the handshake.
- Full pipe with out_ready=1 and in_valid=1: one retires and one enters in the same cycle.
- Empty stages carry valid=0. Their data contents are don't-care, but they must not produce out_valid.
- rst_n asserted mid-operation: in-flight products are discarded immediately and are never emitted.

Optional Feature:
ARRAY_MULT_SIGNED_EN
- Defined: adds input port sgn (1 bit), sampled with a/b on transfer and piped alongside the data.
  - sgn=1 treats a and b as two's complement: sign-extended rows, with the final row subtracted (Baugh-Wooley equivalent).
  - sgn=0 gives unsigned operation. Mixed sgn values in flight must each be handled correctly.
- Undefined: no sgn port, unsigned only, and no extra logic.

Decomposition:
- Package array_mult_pkg holds:
  - function calc_lat(width, rows) returning ceil(width/rows);
  - localparam PW_MULT = 2 (product width factor);
  - the typedef of a stage payload struct {valid, sum, a, b_rem, sgn}.
- One sub-module, array_mult_stage: a combinational row adder for a parametrised row range plus its pipeline register with hold enable. It is instantiated LAT times via generate.

Test Plan:
- WIDTH=4, ROWS_PER_STAGE=1: a=15, b=15, single transfer in cycle 0 -> out_valid in cycle 4, p=225 (0xE1); busy=1 for cycles 1-4 only.
- Back-to-back: 16 consecutive transfers a=i, b=15-i, out_ready=1 -> 16 consecutive out_valid cycles; products 0,14,26,36,44,50,54,56,56,54,50,44,36,26,14,0.
- Backpressure: out_ready=0 for 5 cycles with a full pipe -> in_ready=0, p stable. Then out_ready=1 -> the sequence resumes with no loss or duplication.
- ena=0 for 3 cycles mid-stream -> no state change. On release, results are identical to an uninterrupted run, shifted by 3 cycles.
- Reset mid-operation: rst_n low with 3 products in flight -> out_valid=0 and p=0 immediately (async). No stale product after release.
- WIDTH=7, ROWS_PER_STAGE=3 (LAT=3, remainder stage) with all-ones operands, 127x127 -> p=16129. With ARRAY_MULT_SIGNED_EN and WIDTH=4, sgn=1: -8 x -8 -> 64 (0x40), -8 x 7 -> -56 (0xC8).
